// File: rtl/fd_pkg.sv
// Shared definitions for the fd_multicycle datapath: default widths, op codes, FSM states.
package fd_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_AW_DEF = 5;
  localparam int MEM_AW_DEF = 5;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUBI  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
  } fd_state_t;

endpackage

// File: rtl/fd_reg_bank.sv
// Register bank: two read ports plus a debug read, one write port, x0 hardwired to zero.
// Reads are combinational; the write lands on the rising edge; synchronous reset clears every entry.
module fd_reg_bank #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o     = (ra_i == '0)       ? '0 : regs_q[ra_i];
  assign rd_b_o     = (rb_i == '0)       ? '0 : regs_q[rb_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/fd_multicycle.sv
// Multi-cycle datapath: one ALU/LOAD/STORE per start/done; ALU ops done in cycle 3, LOAD 4, STORE 3, illegal 1.
// start is sampled only in IDLE (never queued); FD_FLAGS_EN adds registered zero/ovf outputs.
module fd_multicycle
  import fd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rw,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef FD_FLAGS_EN
  ,
  output logic              zero,
  output logic              ovf
`endif
);

  localparam int NWORDS = 1 << MEM_AW;

  fd_state_t         state_q, state_d;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] ra_q, rb_q, rw_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, alu_q, ld_q, result_q;
  logic [DATA_W-1:0] rd_a, rd_b, opb, alu_d, rf_wd;
  logic              is_sub, rf_we, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem [NWORDS];

  fd_reg_bank #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .ra_i       (ra_q),
    .rb_i       (rb_q),
    .dbg_addr_i (dbg_addr),
    .we_i       (rf_we),
    .wa_i       (rw_q),
    .wd_i       (rf_wd),
    .rd_a_o     (rd_a),
    .rd_b_o     (rd_b),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    err     = 1'b0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = (op > OP_STORE) ? ST_ERR : ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (op_q == OP_STORE) begin
          done    = 1'b1;
          mem_we  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        done    = 1'b1;
        rf_we   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register-register ops use B; immediate ops and address generation use imm.
  assign opb      = (op_q == OP_ADD || op_q == OP_SUB) ? b_q : imm_q;
  assign is_sub   = (op_q == OP_SUB || op_q == OP_SUBI);
  assign alu_d    = is_sub ? (a_q - opb) : (a_q + opb);
  assign mem_addr = alu_q[MEM_AW-1:0];
  assign rf_wd    = (op_q == OP_LOAD) ? ld_q : alu_q;
  assign busy     = (state_q != ST_IDLE);
  assign result   = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) result_q <= err ? '0 : rf_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      op_q  <= op;
      ra_q  <= ra;
      rb_q  <= rb;
      rw_q  <= rw;
      imm_q <= imm;
    end
    if (state_q == ST_READ) begin
      a_q <= rd_a;
      b_q <= rd_b;
    end
    if (state_q == ST_EXEC) alu_q <= alu_d;
    if (state_q == ST_MEM)  ld_q  <= mem[mem_addr];
  end

  // Memory is never cleared; reset only has to block a store landing on the reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= b_q;
  end

`ifdef FD_FLAGS_EN
  logic zero_q, ovf_q, ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    if (is_sub) ovf_d = (a_q[DATA_W-1] != opb[DATA_W-1]) && (alu_d[DATA_W-1] != a_q[DATA_W-1]);
    else        ovf_d = (a_q[DATA_W-1] == opb[DATA_W-1]) && (alu_d[DATA_W-1] != a_q[DATA_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      zero_q <= (alu_d == '0);
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_fd_multicycle.sv
// Bench for fd_multicycle: directed plan steps then random ops against an architectural model.
module tb_fd_multicycle;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int MW = 5;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op;
  logic [AW-1:0] ra, rb, rw, dbg_addr;
  logic [DW-1:0] imm, result, dbg_data;
  logic          busy, done, err;
`ifdef FD_FLAGS_EN
  logic          zero, ovf;
`endif

  fd_multicycle #(.DATA_W(DW), .REG_AW(AW), .MEM_AW(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rw       (rw),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef FD_FLAGS_EN
    ,
    .zero     (zero),
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] regs_m [32];
  logic [DW-1:0] mem_m  [32];
  bit            mem_v  [32];
  logic [DW-1:0] result_m;
  bit            zero_m, ovf_m;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs_m[i] = '0;
    result_m = '0;
    zero_m   = 1'b0;
    ovf_m    = 1'b0;
  endtask

  task automatic scramble_inputs();
    op  = 3'($urandom_range(0, 7));
    ra  = AW'($urandom);
    rb  = AW'($urandom);
    rw  = AW'($urandom);
    imm = {$urandom, $urandom};
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk(tag, dbg_data, regs_m[i]);
    end
  endtask

  // Issue one op from a negedge in IDLE; returns at the negedge of the cycle after done.
  task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a_i, input logic [AW-1:0] b_i,
                       input logic [AW-1:0] w_i, input logic [DW-1:0] im, input bit hold);
    logic [DW-1:0] av, bv, x, val;
    logic signed [DW:0] wide;
    int  lat, k;
    bit  il, wr;
    av = regs_m[a_i];
    bv = regs_m[b_i];
    il = 1'b0;
    wr = 1'b0;
    x  = im;
    case (o)
      3'd0: begin x = bv; lat = 3; wr = 1'b1; end
      3'd1: begin x = bv; lat = 3; wr = 1'b1; end
      3'd2: begin lat = 3; wr = 1'b1; end
      3'd3: begin lat = 3; wr = 1'b1; end
      3'd4: begin lat = 4; wr = 1'b1; end
      3'd5: begin lat = 3; end
      default: begin lat = 1; il = 1'b1; end
    endcase
    if (o == 3'd1 || o == 3'd3) wide = $signed({av[DW-1], av}) - $signed({x[DW-1], x});
    else                        wide = $signed({av[DW-1], av}) + $signed({x[DW-1], x});
    val = wide[DW-1:0];
    if (!il) begin
      zero_m = (val == '0);
      ovf_m  = (wide[DW] != wide[DW-1]);
    end
    if (il) result_m = '0;
    else if (o == 3'd4) result_m = mem_m[val[MW-1:0]];
    else result_m = val;
    if (o == 3'd5) begin
      mem_m[val[MW-1:0]] = bv;
      mem_v[val[MW-1:0]] = 1'b1;
    end
    if (wr && w_i != '0) regs_m[w_i] = result_m;

    op = o; ra = a_i; rb = b_i; rw = w_i; imm = im; start = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = hold;
      scramble_inputs();
      if (k == 1) chk("busy_c1", busy, 1);
      if (done) break;
    end
    chk("done_cycle", DW'(k), DW'(lat));
    chk("err_at_done", err, il);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("result", result, result_m);
    dbg_addr = w_i;
    #1;
    chk("dbg_rw", dbg_data, regs_m[w_i]);
`ifdef FD_FLAGS_EN
    chk("zero", zero, zero_m);
    chk("ovf", ovf, ovf_m);
`endif
  endtask

  task automatic idle_nodone(input int n);
    int cnt;
    cnt = 0;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("extra_done", DW'(cnt), 0);
  endtask

  initial begin
    logic [2:0]    ro;
    logic [AW-1:0] ra_r, rb_r, rw_r;
    logic [DW-1:0] im_r, addr_r;

    rst = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0; imm = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mem_v[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    sweep("rst_regs");

    do_op(3'd2, 0, 0, 1, 64'd5, 1'b0);
    do_op(3'd1, 1, 1, 2, 64'd0, 1'b0);
    do_op(3'd5, 1, 1, 0, 64'd3, 1'b0);
    do_op(3'd4, 0, 0, 3, 64'd40, 1'b0);
    do_op(3'd2, 0, 0, 0, 64'd7, 1'b0);
    do_op(3'd6, 1, 2, 5, 64'd9, 1'b0);
    do_op(3'd7, 3, 3, 6, 64'd1, 1'b0);

    // start held high through a transaction with changing inputs
    do_op(3'd2, 1, 0, 6, 64'd1, 1'b1);
    idle_nodone(5);

    do_op(3'd2, 0, 0, 7, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    do_op(3'd2, 0, 0, 8, 64'd1, 1'b0);
    do_op(3'd0, 7, 8, 9, 64'd0, 1'b0);
    chk("ovf_sum", result, 64'h8000_0000_0000_0000);

    for (int n = 0; n < 80; n++) begin
      ro   = 3'($urandom_range(0, 7));
      if (n < 10) ro = 3'd2;
      ra_r = AW'($urandom);
      rb_r = AW'($urandom);
      rw_r = AW'($urandom);
      im_r = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 100));
      addr_r = regs_m[ra_r] + im_r;
      if (ro == 3'd4 && !mem_v[addr_r[MW-1:0]]) ro = 3'd5;
      do_op(ro, ra_r, rb_r, rw_r, im_r, 1'b0);
    end
    sweep("rand_regs");

    // reset on the STORE's done edge must not write memory
    do_op(3'd2, 0, 0, 10, ~mem_m[8], 1'b0);
    op = 3'd5; ra = '0; rb = 5'd10; rw = '0; imm = 64'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("st_done_c3", done, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("st_rst_busy", busy, 0);
    chk("st_rst_result", result, 0);
    do_op(3'd4, 0, 0, 1, 64'd8, 1'b0);

    // reset during EXEC of ADDI rw=4
    op = 3'd2; ra = '0; rb = '0; rw = 5'd4; imm = 64'h55; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("ex_rst_busy", busy, 0);
    chk("ex_rst_done", done, 0);
    chk("ex_rst_result", result, 0);
    idle_nodone(5);
    sweep("ex_rst_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_multicycle.md
# fd_multicycle

Parametrised multi-cycle datapath, successor to the single-cycle processor datapath. Holds a register bank and a data memory, executes one ADD/SUB/ADDI/SUBI/LOAD/STORE per start/done transaction through an internal state machine, and adds configurable widths and depths, x0-hardwired-zero, illegal-op reporting and a debug read port. Sits under the processor control unit, which issues operations and waits for `done`.

## Interface
- DATA_W, 64: data/register width
- REG_AW, 5: register address width; 2**REG_AW registers
- MEM_AW, 5: memory address width; 2**MEM_AW words of DATA_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  issue request; sampled only in IDLE
- op  in  3  0 ADD, 1 SUB, 2 ADDI, 3 SUBI, 4 LOAD, 5 STORE, 6–7 illegal
- ra, rb, rw  in  REG_AW each  source A, source B, destination
- imm  in  DATA_W  signed offset/immediate (already extended)
- busy  out  1  high from the cycle after accept until the last cycle of the transaction
- done  out  1  one-cycle pulse in the final cycle of a transaction
- err  out  1  high with `done` for illegal op
- result  out  DATA_W  registered value of the last completed op
- dbg_addr  in  REG_AW; dbg_data  out  DATA_W  combinational register read

## Operation
- op, ra, rb, rw, imm latched at accept (IDLE & start); later input changes ignored.
- States: IDLE → READ (latch regs[ra], regs[rb]) → EXEC (ALU result registered) → MEM (LOAD/STORE only) → WB (LOAD, ALU ops) → IDLE. Illegal op: IDLE → ERR → IDLE.
- ALU: ADD A+B, SUB A−B, ADDI A+imm, SUBI A−imm; LOAD/STORE address A+imm. Modulo 2**DATA_W; memory address = low MEM_AW bits (wrap, no error).
- LOAD: MEM reads mem[addr] into a register; WB writes it to rw. STORE: mem[addr] ← B at end of MEM; no register write; done in MEM.
- Register 0 reads as 0; writes to rw=0 suppressed, transaction still completes with done.
- result: ALU value (ALU ops), loaded data (LOAD), address (STORE), 0 (illegal). Updated in the done cycle; visible the cycle after.
- start while busy: ignored, not queued.
- Reset: state IDLE, busy 0, done 0, err 0, result 0, all registers 0. Memory contents not cleared. Reset mid-transaction aborts; no register or memory write occurs at or after the reset edge.

## Timing
- Accept edge = cycle 0. ALU ops: READ 1, EXEC 2, WB 3 (done, write at end of 3). LOAD: done in cycle 4. STORE: done in cycle 3. Illegal: done+err in cycle 1.
- Next start accepted in the cycle after done (back-to-back: ALU op every 4 cycles).
- Register write in WB visible on dbg_data and to a following READ on the next cycle.

## Configuration
- FD_FLAGS_EN defined: extra outputs `zero` and `ovf` (1 bit each), registered in EXEC from the ALU result (zero = result==0, ovf = signed overflow of add/sub), reset 0, held until next EXEC.
- Undefined: ports and logic absent; all other behaviour identical.

## Structure
- Package fd_pkg: op encoding constants, state enum, DATA_W/REG_AW/MEM_AW defaults.
- One sub-module: fd_reg_bank (2 registered-use read ports + debug read, 1 write port, x0 zero, synchronous reset clear). FSM, ALU and memory array inline.

## Test plan
- Reset, then dbg_addr sweep 0..31 → dbg_data all 0; busy/done/result 0.
- ADDI ra=0, imm=5, rw=1 → done in cycle 3, result 5, regs[1]=5; then SUB ra=1, rb=1, rw=2 → regs[2]=0 (FD_FLAGS_EN: zero=1).
- STORE ra=1 (5), rb=1, imm=3 → done cycle 3, mem[8]=5; LOAD ra=0, imm=40, rw=3 → wraps to mem[8], regs[3]=5, done cycle 4.
- ADDI rw=0, imm=7 → done, regs[0] still 0; op=6 → done+err in cycle 1, no state change, result 0.
- start pulsed during busy → ignored, exactly one done; rst asserted in EXEC of ADDI rw=4 → regs[4]=0, IDLE next cycle.
- FD_FLAGS_EN: ADD 0x7FFF…F + 1 → result 0x8000…0, ovf=1.
